// File: rtl/nibble_serial_add_ctrl_pkg.sv
// Shared definitions for the nibble-serial adder sequencer.
//   SLICE_W   : width of one adder slice (nibble)
//   state_e   : sequencer state encoding
//   idx_width : width of the slice index counter (at least 1 bit)
package nibble_serial_add_ctrl_pkg;

    localparam int unsigned SLICE_W = 4;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } state_e;

    function automatic int unsigned idx_width(int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/nibble_serial_add_ctrl_if.sv
// Requester and adder-side signals of the nibble-serial adder sequencer.
//   start/a/b/cin       : request from the requester
//   busy/done/sum/cout  : status and result back to the requester
//   add_a/add_b/add_cin : operand slice and chained carry to the external 4-bit adder
//   add_s/add_cout      : combinational result of the external 4-bit adder
// master = requester/adder side, slave = sequencer.
interface nibble_serial_add_ctrl_if #(
    parameter int unsigned WIDTH = 16
);

    logic                                        start;
    logic [WIDTH-1:0]                            a;
    logic [WIDTH-1:0]                            b;
    logic                                        cin;
    logic                                        busy;
    logic                                        done;
    logic [WIDTH-1:0]                            sum;
    logic                                        cout;
    logic [nibble_serial_add_ctrl_pkg::SLICE_W-1:0] add_a;
    logic [nibble_serial_add_ctrl_pkg::SLICE_W-1:0] add_b;
    logic                                        add_cin;
    logic [nibble_serial_add_ctrl_pkg::SLICE_W-1:0] add_s;
    logic                                        add_cout;

    modport master (
        output start, a, b, cin,
        input  busy, done, sum, cout,
        input  add_a, add_b, add_cin,
        output add_s, add_cout
    );

    modport slave (
        input  start, a, b, cin,
        output busy, done, sum, cout,
        output add_a, add_b, add_cin,
        input  add_s, add_cout
    );

endinterface

// File: rtl/full_adder_4bits_bh.sv
// Shared combinational 4-bit adder used as the datapath of the serial adder.
//   a_i, b_i : 4-bit operands
//   cin_i    : carry-in
//   s_o      : 4-bit sum
//   cout_o   : carry-out
module full_adder_4bits_bh (
    input  logic [3:0] a_i,
    input  logic [3:0] b_i,
    input  logic       cin_i,
    output logic [3:0] s_o,
    output logic       cout_o
);

    assign {cout_o, s_o} = 5'(a_i) + 5'(b_i) + 5'(cin_i);

endmodule

// File: rtl/nibble_serial_add_ctrl.sv
// Sequencer performing a WIDTH-bit add on an external 4-bit adder, one nibble
// per clock, LSB first, carry chained through a register.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : slave side of nibble_serial_add_ctrl_if (request, result, adder wiring)
module nibble_serial_add_ctrl
    import nibble_serial_add_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input logic                    clk,
    input logic                    rst_n,
    nibble_serial_add_ctrl_if.slave bus
);

    localparam int unsigned NSLICE = WIDTH / SLICE_W;
    localparam int unsigned IdxW   = idx_width(NSLICE);

    state_e           state_q;
    logic [IdxW-1:0]  idx_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             carry_q;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;
    logic             busy_q;
    logic             done_q;

    logic             last_slice;

    assign last_slice = (idx_q == IdxW'(NSLICE - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle, StDone: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
                        a_q     <= bus.a;
                        b_q     <= bus.b;
                        carry_q <= bus.cin;
                        idx_q   <= '0;
                        sum_q   <= '0;
                        cout_q  <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= StRun;
                    end else begin
                        state_q <= StIdle;
                    end
                end
                StRun: begin
                    // start is deliberately not looked at here: no queueing.
                    for (int unsigned i = 0; i < NSLICE; i++) begin
                        if (idx_q == IdxW'(i)) begin
                            sum_q[i*SLICE_W +: SLICE_W] <= bus.add_s;
                        end
                    end
                    carry_q <= bus.add_cout;
                    if (last_slice) begin
                        cout_q  <= bus.add_cout;
                        idx_q   <= '0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= StDone;
                    end else begin
                        idx_q <= idx_q + IdxW'(1);
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= StIdle;
                end
            endcase
        end
    end

    // Adder inputs are only live in RUN so an idle adder sees constant zeros.
    always_comb begin
        bus.add_a   = '0;
        bus.add_b   = '0;
        bus.add_cin = 1'b0;
        if (state_q == StRun) begin
            for (int unsigned i = 0; i < NSLICE; i++) begin
                if (idx_q == IdxW'(i)) begin
                    bus.add_a = a_q[i*SLICE_W +: SLICE_W];
                    bus.add_b = b_q[i*SLICE_W +: SLICE_W];
                end
            end
            bus.add_cin = carry_q;
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.sum  = sum_q;
    assign bus.cout = cout_q;

endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// Self-checking bench: sequencer plus the shared 4-bit adder, WIDTH=16.
module tb_nibble_serial_add_ctrl;

    localparam int unsigned W = 16;

    logic clk;
    logic rst_n;

    nibble_serial_add_ctrl_if #(.WIDTH(W)) bus ();

    nibble_serial_add_ctrl #(.WIDTH(W)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    full_adder_4bits_bh u_add (
        .a_i    (bus.add_a),
        .b_i    (bus.add_b),
        .cin_i  (bus.add_cin),
        .s_o    (bus.add_s),
        .cout_o (bus.add_cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Scoreboard of expected {cout, sum}, pushed at drive time.
    logic [W:0] sb[$];

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic [W-1:0] sum;
        logic         cout;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Result checking happens here whenever done is seen.
    always @(negedge clk) begin
        logic [W:0] e;
        if (rst_n && bus.done) begin
            if (sb.size() == 0) begin
                check("spurious_done", 32'(bus.done), 32'd0);
            end else begin
                e = sb.pop_front();
                check("sum", 32'(bus.sum), 32'(e[W-1:0]));
                check("cout", 32'(bus.cout), 32'(e[W]));
            end
        end
    end

    task automatic drive(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                         input logic [W:0] exp);
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = a;
        bus.b     = b;
        bus.cin   = cin;
        sb.push_back(exp);
        @(posedge clk);
        #1 bus.start = 1'b0;
    endtask

    // Bounded wait for done, counting busy cycles on the way.
    task automatic wait_done(input string name, input int exp_busy);
        int  n_busy = 0;
        bit  seen   = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (bus.done) begin
                seen = 1'b1;
                break;
            end
            if (bus.busy) n_busy++;
        end
        check({name, "_done_seen"}, 32'(seen), 32'd1);
        check({name, "_busy_cycles"}, 32'(n_busy), 32'(exp_busy));
    endtask

    initial begin
        logic [3:0]   chain;
        logic [W-1:0] ra, rb;
        logic         rc;
        int           n_done;

        vecs[0] = '{a: 16'hFFFF, b: 16'h0001, cin: 1'b0, sum: 16'h0000, cout: 1'b1};
        vecs[1] = '{a: 16'h1234, b: 16'h4321, cin: 1'b1, sum: 16'h5556, cout: 1'b0};
        vecs[2] = '{a: 16'h000F, b: 16'h0001, cin: 1'b0, sum: 16'h0010, cout: 1'b0};
        vecs[3] = '{a: 16'h8000, b: 16'h8000, cin: 1'b0, sum: 16'h0000, cout: 1'b1};
        vecs[4] = '{a: 16'h7FFF, b: 16'h0001, cin: 1'b1, sum: 16'h8001, cout: 1'b0};
        vecs[5] = '{a: 16'hFFFF, b: 16'hFFFF, cin: 1'b1, sum: 16'hFFFF, cout: 1'b1};
        vecs[6] = '{a: 16'h0000, b: 16'h0000, cin: 1'b0, sum: 16'h0000, cout: 1'b0};

        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        bus.cin   = 1'b0;

        // Reset values.
        rst_n = 1'b0;
        #2;
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_sum", 32'(bus.sum), 32'd0);
        check("rst_cout", 32'(bus.cout), 32'd0);
        check("rst_add_a", 32'(bus.add_a), 32'd0);
        check("rst_add_b", 32'(bus.add_b), 32'd0);
        check("rst_add_cin", 32'(bus.add_cin), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Table-driven ops: 4 busy cycles then done.
        for (int i = 0; i < 7; i++) begin
            drive(vecs[i].a, vecs[i].b, vecs[i].cin, {vecs[i].cout, vecs[i].sum});
            wait_done($sformatf("vec%0d", i), 4);
            @(negedge clk);
            check($sformatf("vec%0d_idle_add_a", i), 32'(bus.add_a), 32'd0);
        end

        // Carry chain seen on add_cin: 1,0,0,0.
        drive(16'h1234, 16'h4321, 1'b1, {1'b0, 16'h5556});
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("chain_busy", 32'(bus.busy), 32'd1);
            chain[k] = bus.add_cin;
        end
        check("cin_chain", 32'(chain), 32'h1);
        @(negedge clk);
        check("chain_done", 32'(bus.done), 32'd1);

        // start held through RUN is ignored; start in DONE chains a new op.
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = 16'h1111;
        bus.b     = 16'h2222;
        bus.cin   = 1'b0;
        sb.push_back({1'b0, 16'h3333});
        @(posedge clk);
        #1;
        bus.a = 16'h000F;
        bus.b = 16'h0001;
        sb.push_back({1'b0, 16'h0010});
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("held_busy", 32'(bus.busy), 32'd1);
        end
        @(negedge clk);
        check("held_done", 32'(bus.done), 32'd1);
        @(posedge clk);
        #1 bus.start = 1'b0;
        @(negedge clk);
        check("b2b_busy", 32'(bus.busy), 32'd1);
        wait_done("b2b", 3);

        // Reset in the 2nd RUN cycle aborts with no done.
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = 16'h1234;
        bus.b     = 16'h1111;
        bus.cin   = 1'b0;
        @(posedge clk);
        #1 bus.start = 1'b0;
        @(posedge clk);
        #1;
        check("pre_abort_sum", 32'(bus.sum), 32'h0005);
        rst_n = 1'b0;
        #1;
        check("abort_busy", 32'(bus.busy), 32'd0);
        check("abort_done", 32'(bus.done), 32'd0);
        check("abort_sum", 32'(bus.sum), 32'd0);
        check("abort_add_a", 32'(bus.add_a), 32'd0);
        check("abort_add_cin", 32'(bus.add_cin), 32'd0);
        @(negedge clk);
        rst_n  = 1'b1;
        n_done = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (bus.done) n_done++;
        end
        check("abort_no_done", 32'(n_done), 32'd0);
        drive(16'h8000, 16'h8000, 1'b0, {1'b1, 16'h0000});
        wait_done("post_abort", 4);

        // Random ops against a+b+cin.
        for (int n = 0; n < 200; n++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            rc = 1'($urandom_range(1));
            drive(ra, rb, rc, {1'b0, ra} + {1'b0, rb} + (W+1)'(rc));
            wait_done("rand", 4);
        end

        @(negedge clk);
        check("sb_empty", 32'(sb.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
